// File: rtl/mips_trace_pkg.sv
// Shared definitions for the MIPS execution-trace buffer: state encoding, entry width and field offsets.
// Store fields (mem_write, mem_addr, mem_wdata) are carried in each entry only when TRACE_MEMW_EN is defined.
package mips_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_POST = 2'd2,
      ST_DONE = 2'd3
   } trace_state_e;

   localparam int INSN_W = 32;

`ifdef TRACE_MEMW_EN
   localparam bit MEMW_EN = 1'b1;
`else
   localparam bit MEMW_EN = 1'b0;
`endif

   function automatic int entry_w(int pc_w, int data_w, int reg_aw);
      return pc_w + INSN_W + 1 + reg_aw + data_w + (MEMW_EN ? 1 + 2 * data_w : 0);
   endfunction

   // Offsets are counted from the LSB; store fields occupy the bottom of the entry when present.
   function automatic int off_md(int data_w);
      return 0 * data_w;
   endfunction

   function automatic int off_ma(int data_w);
      return data_w;
   endfunction

   function automatic int off_mw(int data_w);
      return 2 * data_w;
   endfunction

   function automatic int off_wb(int data_w);
      return MEMW_EN ? 1 + 2 * data_w : 0;
   endfunction

   function automatic int off_wreg(int data_w);
      return off_wb(data_w) + data_w;
   endfunction

   function automatic int off_rw(int data_w, int reg_aw);
      return off_wreg(data_w) + reg_aw;
   endfunction

   function automatic int off_insn(int data_w, int reg_aw);
      return off_rw(data_w, reg_aw) + 1;
   endfunction

   function automatic int off_pc(int data_w, int reg_aw);
      return off_insn(data_w, reg_aw) + INSN_W;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one synchronous write port, one registered read port.
// The read register clears on reset so the buffer presents an all-zero entry after reset.
module trace_ram #(
   parameter  int DEPTH   = 16,
   parameter  int ENTRY_W = 64,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [ENTRY_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [ENTRY_W-1:0] rdata
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clock) begin
      if (reset) rdata <= '0;
      else       rdata <= mem[raddr];
   end

endmodule

// File: rtl/mips_trace_buffer.sv
// Execution-trace capture for the single-cycle MIPS core: circular capture, PC trigger, oldest-first drain.
// Define TRACE_MEMW_EN to include store fields in each entry; otherwise the mem_* inputs are ignored.
module mips_trace_buffer
   import mips_trace_pkg::*;
#(
   parameter  int PC_W    = 10,
   parameter  int DATA_W  = 16,
   parameter  int REG_AW  = 4,
   parameter  int DEPTH   = 16,
   localparam int AW      = $clog2(DEPTH),
   localparam int ENTRY_W = entry_w(PC_W, DATA_W, REG_AW)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               retire,
   input  logic [PC_W-1:0]    pc,
   input  logic [31:0]        instruction,
   input  logic               reg_write,
   input  logic [REG_AW-1:0]  write_reg,
   input  logic [DATA_W-1:0]  write_back,
   input  logic               mem_write,
   input  logic [DATA_W-1:0]  mem_addr,
   input  logic [DATA_W-1:0]  mem_wdata,
   input  logic               arm,
   input  logic [PC_W-1:0]    trig_pc,
   input  logic [AW-1:0]      post_count,
   input  logic               rd_req,
   output logic               rd_valid,
   output logic [ENTRY_W-1:0] rd_data,
   output logic [1:0]         state,
   output logic [AW:0]        count
);

   localparam int OFF_WB   = off_wb(DATA_W);
   localparam int OFF_WREG = off_wreg(DATA_W);
   localparam int OFF_RW   = off_rw(DATA_W, REG_AW);
   localparam int OFF_INSN = off_insn(DATA_W, REG_AW);
   localparam int OFF_PC   = off_pc(DATA_W, REG_AW);
   localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

   trace_state_e       st;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr_p0;
   logic               vld_p0;
   logic [AW-1:0]      remain;
   logic [AW-1:0]      raddr;
   logic               wr_en;
   logic               pop;
   logic [ENTRY_W-1:0] wr_entry;

   assign state = st;
   assign wr_en = retire && (st == ST_PRE || st == ST_POST);
   assign pop   = (st == ST_DONE) && rd_valid && rd_req && !arm;
   // Read one entry ahead on a pop so the next entry is on rd_data the following cycle.
   assign raddr = pop ? rd_ptr_p0 + 1'b1 : rd_ptr_p0;

   always_comb begin
      wr_entry = '0;
      wr_entry[OFF_PC   +: PC_W]   = pc;
      wr_entry[OFF_INSN +: INSN_W] = instruction;
      wr_entry[OFF_RW]             = reg_write;
      wr_entry[OFF_WREG +: REG_AW] = write_reg;
      wr_entry[OFF_WB   +: DATA_W] = write_back;
`ifdef TRACE_MEMW_EN
      wr_entry[off_mw(DATA_W)]          = mem_write;
      wr_entry[off_ma(DATA_W) +: DATA_W] = mem_addr;
      wr_entry[off_md(DATA_W) +: DATA_W] = mem_wdata;
`endif
   end

`ifndef TRACE_MEMW_EN
   logic unused_mem;
   assign unused_mem = ^{mem_write, mem_addr, mem_wdata};
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         st        <= ST_IDLE;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr_p0 <= '0;
         vld_p0    <= 1'b0;
         remain    <= '0;
         rd_valid  <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count != CNT_FULL) count <= count + 1'b1;
         end
         unique case (st)
            ST_IDLE, ST_DONE: begin
               if (arm) begin
                  st       <= ST_PRE;
                  count    <= '0;
                  wr_ptr   <= '0;
                  vld_p0   <= 1'b0;
                  rd_valid <= 1'b0;
               end else if (st == ST_DONE) begin
                  // stage p0: oldest entry sits count slots behind the write pointer
                  if (!vld_p0) begin
                     rd_ptr_p0 <= wr_ptr - count[AW-1:0];
                     vld_p0    <= 1'b1;
                  // stage p1: RAM read lands on rd_data
                  end else if (pop) begin
                     rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
                     count     <= count - 1'b1;
                     rd_valid  <= (count != (AW + 1)'(1));
                  end else begin
                     rd_valid  <= (count != '0);
                  end
               end
            end
            ST_PRE: begin
               if (retire && pc == trig_pc) begin
                  if (post_count == '0) begin
                     st <= ST_DONE;
                  end else begin
                     st     <= ST_POST;
                     remain <= post_count;
                  end
               end
            end
            ST_POST: begin
               if (retire) begin
                  remain <= remain - 1'b1;
                  if (remain == AW'(1)) st <= ST_DONE;
               end
            end
         endcase
      end
   end

   trace_ram #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) u_ram (
      .clock (clock),
      .reset (reset),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (raddr),
      .rdata (rd_data)
   );

endmodule
